// File: rtl/fifo_req_ack_slave.sv
// Single-clock FIFO acting as req/ack slave on both push and pop ports; each port runs 4-phase handshake or stream mode.
// Optional build macro FIFO_STATUS_EN adds the level and almost_full status ports.
module fifo_req_ack_slave #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_stream_mode,
  input  logic                     push_req,
  input  logic [WIDTH-1:0]         push_data_in,
  output logic                     push_ack,
  output logic                     push_ack_pulse,
  output logic                     fifo_full,
  input  logic                     pop_stream_mode,
  input  logic                     pop_req,
  output logic [WIDTH-1:0]         pop_data_out,
  output logic                     pop_ack,
  output logic                     pop_ack_pulse,
  output logic                     fifo_empty
`ifdef FIFO_STATUS_EN
  ,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} hs_state_e;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_MARGIN < 0 || AF_MARGIN >= DEPTH) begin : g_bad_params
    $error("fifo_req_ack_slave: DEPTH must be a power of two >= 2 and AF_MARGIN in [0, DEPTH)");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             fifo_full_q, fifo_full_d, fifo_empty_q, fifo_empty_d;

  hs_state_e        push_state_q, push_state_d, pop_state_q, pop_state_d;
  logic             push_mode_q, push_mode_d, pop_mode_q, pop_mode_d;
  logic             push_ack_q, push_ack_d, push_pulse_q, push_pulse_d;
  logic             pop_ack_q, pop_ack_d, pop_pulse_q, pop_pulse_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;

  logic push_hs_we_s, push_st_ack_s, push_we_s;
  logic pop_hs_re_s, pop_st_ack_s, pop_re_s;

  // Stream acks use the registered flags, so a pop never frees space for a same-cycle push and vice versa.
  assign push_hs_we_s  = (push_state_q == S_IDLE) & ~push_mode_q & push_req & ~fifo_full_q;
  assign push_st_ack_s = push_mode_q & push_req & ~fifo_full_q;
  assign push_we_s     = push_hs_we_s | push_st_ack_s;
  assign pop_hs_re_s   = (pop_state_q == S_IDLE) & ~pop_mode_q & pop_req & ~fifo_empty_q;
  assign pop_st_ack_s  = pop_mode_q & pop_req & ~fifo_empty_q;
  assign pop_re_s      = pop_hs_re_s | pop_st_ack_s;

  assign push_ack       = push_mode_q ? push_st_ack_s : push_ack_q;
  assign push_ack_pulse = push_mode_q ? push_st_ack_s : push_pulse_q;
  assign pop_ack        = pop_mode_q  ? pop_st_ack_s  : pop_ack_q;
  assign pop_ack_pulse  = pop_mode_q  ? pop_st_ack_s  : pop_pulse_q;
  assign pop_data_out   = pop_mode_q  ? mem_q[rd_ptr_q] : pop_data_q;
  assign fifo_full      = fifo_full_q;
  assign fifo_empty     = fifo_empty_q;

  // Push FSM next state
  always_comb begin
    push_state_d = push_state_q;
    case (push_state_q)
      S_IDLE:  if (push_hs_we_s) push_state_d = S_ACK;  else push_state_d = S_IDLE;
      S_ACK:   if (!push_req)    push_state_d = S_IDLE; else push_state_d = S_ACK;
      default: push_state_d = S_IDLE;
    endcase
  end

  // Pop FSM next state
  always_comb begin
    pop_state_d = pop_state_q;
    case (pop_state_q)
      S_IDLE:  if (pop_hs_re_s) pop_state_d = S_ACK;  else pop_state_d = S_IDLE;
      S_ACK:   if (!pop_req)    pop_state_d = S_IDLE; else pop_state_d = S_ACK;
      default: pop_state_d = S_IDLE;
    endcase
  end

  // Registered handshake outputs and mode latches
  always_comb begin
    push_ack_d   = (push_state_d == S_ACK);
    push_pulse_d = push_hs_we_s;
    pop_ack_d    = (pop_state_d == S_ACK);
    pop_pulse_d  = pop_hs_re_s;
    if (pop_re_s) pop_data_d = mem_q[rd_ptr_q];
    else          pop_data_d = pop_data_q;
    if (push_state_q == S_IDLE && !push_req) push_mode_d = push_stream_mode;
    else                                     push_mode_d = push_mode_q;
    if (pop_state_q == S_IDLE && !pop_req) pop_mode_d = pop_stream_mode;
    else                                   pop_mode_d = pop_mode_q;
  end

  // Pointers, occupancy and flags derived from next count
  always_comb begin
    if (push_we_s) wr_ptr_d = wr_ptr_q + PW'(1); else wr_ptr_d = wr_ptr_q;
    if (pop_re_s)  rd_ptr_d = rd_ptr_q + PW'(1); else rd_ptr_d = rd_ptr_q;
    case ({push_we_s, pop_re_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    fifo_full_d  = (count_d == DEPTH_C);
    fifo_empty_d = (count_d == {CW{1'b0}});
  end

  // State register for both FSMs, pointers and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_state_q <= S_IDLE;
      pop_state_q  <= S_IDLE;
      push_mode_q  <= 1'b0;
      pop_mode_q   <= 1'b0;
      push_ack_q   <= 1'b0;
      push_pulse_q <= 1'b0;
      pop_ack_q    <= 1'b0;
      pop_pulse_q  <= 1'b0;
      pop_data_q   <= {WIDTH{1'b0}};
      wr_ptr_q     <= {PW{1'b0}};
      rd_ptr_q     <= {PW{1'b0}};
      count_q      <= {CW{1'b0}};
      fifo_full_q  <= 1'b0;
      fifo_empty_q <= 1'b1;
    end else begin
      push_state_q <= push_state_d;
      pop_state_q  <= pop_state_d;
      push_mode_q  <= push_mode_d;
      pop_mode_q   <= pop_mode_d;
      push_ack_q   <= push_ack_d;
      push_pulse_q <= push_pulse_d;
      pop_ack_q    <= pop_ack_d;
      pop_pulse_q  <= pop_pulse_d;
      pop_data_q   <= pop_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_full_q  <= fifo_full_d;
      fifo_empty_q <= fifo_empty_d;
    end
  end

  // Storage array; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (push_we_s) mem_q[wr_ptr_q] <= push_data_in;
  end

`ifdef FIFO_STATUS_EN
  localparam logic [CW-1:0] AF_LEVEL_C = CW'(DEPTH - AF_MARGIN);
  logic almost_full_q;

  // Almost-full flag tracks the same next count as fifo_full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) almost_full_q <= 1'b0;
    else     almost_full_q <= (count_d >= AF_LEVEL_C);
  end

  assign level       = count_q;
  assign almost_full = almost_full_q;
`endif

endmodule
